// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: the CPU-facing register port and the
// DMA master port that the MMU arbitrates.
interface oam_dma_if;
  // CPU register port
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_read_en;
  logic        reg_write_en;
  logic [7:0]  reg_rdata;
  // DMA master port
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_read_en;
  logic        dma_write_en;
  logic        dma_active;

  // View taken by the DMA engine (it is the initiator on the dma_* bus)
  modport master (
    input  reg_addr, reg_wdata, reg_read_en, reg_write_en,
    output reg_rdata,
    output dma_addr, dma_wdata, dma_read_en, dma_write_en, dma_active,
    input  dma_rdata
  );

  // View taken by the surrounding system (CPU + MMU/memory)
  modport slave (
    output reg_addr, reg_wdata, reg_read_en, reg_write_en,
    input  reg_rdata,
    input  dma_addr, dma_wdata, dma_read_en, dma_write_en, dma_active,
    output dma_rdata
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to the page register copies LENGTH bytes from
// {page,8'h00} to OAM_BASE, one byte per CYCLES_PER_BYTE clocks
// (READ, WRITE, then PAD idle clocks), after an initial START delay.
module oam_dma #(
  parameter logic [15:0] REG_ADDR        = 16'hFF46,
  parameter logic [15:0] OAM_BASE        = 16'hFE00,
  parameter int          LENGTH          = 160,
  parameter int          CYCLES_PER_BYTE = 4
) (
  input  logic      clk,
  input  logic      reset,
  oam_dma_if.master bus
);

  localparam int SW         = $clog2(CYCLES_PER_BYTE) + 1;
  localparam int PAD_CYCLES = CYCLES_PER_BYTE - 2;
  localparam logic [SW-1:0] START_LAST = SW'(CYCLES_PER_BYTE - 1);
  localparam logic [SW-1:0] PAD_LAST   = SW'((PAD_CYCLES > 0) ? (PAD_CYCLES - 1) : 0);
  localparam logic [7:0]    LAST_INDEX = 8'(LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    READ,
    WRITE,
    PAD
  } state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] slot_reg, slot_next;
  logic [7:0]    index_reg, index_next;
  logic [7:0]    page_reg, page_next;
  logic [7:0]    src_hi_reg, src_hi_next;
  logic [7:0]    latch_reg, latch_next;

  logic trigger;
  logic byte_done;

  assign trigger = bus.reg_write_en && (bus.reg_addr == REG_ADDR);

  // A byte slot ends after its PAD clocks, or straight after WRITE when there is no padding
  assign byte_done = ((state_reg == WRITE) && (PAD_CYCLES == 0)) ||
                     ((state_reg == PAD) && (slot_reg == PAD_LAST));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      slot_reg   <= '0;
      index_reg  <= 8'h00;
      page_reg   <= 8'hFF;
      src_hi_reg <= 8'h00;
      latch_reg  <= 8'h00;
    end else begin
      state_reg  <= state_next;
      slot_reg   <= slot_next;
      index_reg  <= index_next;
      page_reg   <= page_next;
      src_hi_reg <= src_hi_next;
      latch_reg  <= latch_next;
    end
  end

  // Next-state logic; a trigger overrides everything and restarts the copy
  always_comb begin
    state_next  = state_reg;
    slot_next   = slot_reg;
    index_next  = index_reg;
    page_next   = page_reg;
    src_hi_next = src_hi_reg;
    latch_next  = latch_reg;

    case (state_reg)
      IDLE: begin
        state_next = IDLE;
      end
      START: begin
        if (slot_reg == START_LAST) begin
          state_next = READ;
          slot_next  = '0;
        end else begin
          slot_next = slot_reg + 1'b1;
        end
      end
      READ: begin
        latch_next = bus.dma_rdata;
        state_next = WRITE;
      end
      WRITE: begin
        state_next = PAD;
        slot_next  = '0;
      end
      PAD: begin
        slot_next = slot_reg + 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (byte_done) begin
      slot_next = '0;
      if (index_reg == LAST_INDEX) begin
        state_next = IDLE;
      end else begin
        index_next = index_reg + 8'd1;
        state_next = READ;
      end
    end

    if (trigger) begin
      page_next   = bus.reg_wdata;
      // Pages E0..FF are the echo of C0..DF
      src_hi_next = (bus.reg_wdata < 8'hE0) ? bus.reg_wdata : (bus.reg_wdata - 8'h20);
      index_next  = 8'h00;
      slot_next   = '0;
      state_next  = START;
    end
  end

  // Master-port strobes, address and data decoded from the current state
  always_comb begin
    bus.dma_read_en  = 1'b0;
    bus.dma_write_en = 1'b0;
    bus.dma_addr     = 16'h0000;
    bus.dma_wdata    = 8'h00;
    case (state_reg)
      READ: begin
        bus.dma_read_en = 1'b1;
        bus.dma_addr    = {src_hi_reg, index_reg};
      end
      WRITE: begin
        bus.dma_write_en = 1'b1;
        bus.dma_addr     = OAM_BASE + {8'h00, index_reg};
        bus.dma_wdata    = latch_reg;
      end
      default: begin
        bus.dma_read_en = 1'b0;
      end
    endcase
  end

  // Busy flag and combinational register read-back
  always_comb begin
    bus.dma_active = (state_reg != IDLE);
    bus.reg_rdata  = (bus.reg_read_en && (bus.reg_addr == REG_ADDR)) ? page_reg : 8'h00;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a bench memory serves the master port,
// and a timing model derived from the trigger cycle predicts every cycle.
module tb_oam_dma;
  logic clk;
  logic reset;
  oam_dma_if bif ();

  oam_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  // model state: armed by a trigger, timed from t0 (first active cycle)
  bit         armed = 1'b0;
  int         t0 = 0;
  logic [7:0] src_hi = 8'h00;

  assign bif.dma_rdata = mem[bif.dma_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bif.dma_write_en) mem[bif.dma_addr] <= bif.dma_wdata;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Every-cycle comparison against the timing model
  always @(negedge clk) begin
    if (cyc > 0) begin
      int d, k, i;
      logic        e_act, e_re, e_we;
      logic [15:0] e_addr;
      logic [7:0]  e_wd;
      e_act = 0; e_re = 0; e_we = 0; e_addr = 16'h0; e_wd = 8'h0;
      d = cyc - t0;
      if (armed && d >= 0 && d <= 4 * 160 + 3) begin
        e_act = 1;
        if (d >= 4) begin
          k = d - 4;
          i = k / 4;
          if (k % 4 == 0) begin
            e_re = 1; e_addr = {src_hi, 8'(i)};
          end else if (k % 4 == 1) begin
            e_we = 1; e_addr = 16'hFE00 + 16'(i); e_wd = mem[{src_hi, 8'(i)}];
          end
        end
      end
      check("cycle", {37'h0, bif.dma_active, bif.dma_read_en, bif.dma_write_en, bif.dma_addr, bif.dma_wdata},
                     {37'h0, e_act, e_re, e_we, e_addr, e_wd});
    end
  end

  task automatic trigger(input logic [15:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    bif.reg_addr = a; bif.reg_wdata = v; bif.reg_write_en = 1'b1;
    @(posedge clk); #1;
    bif.reg_write_en = 1'b0;
    if (a == 16'hFF46) begin
      armed = 1'b1; t0 = cyc; src_hi = (v < 8'hE0) ? v : v - 8'h20;
    end
    $display("write %h <= %h at cycle %0d", a, v, cyc);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    armed = 1'b0;
    $display("reset pulse at cycle %0d", cyc);
  endtask

  task automatic reg_read(input string name, input logic [15:0] a, input logic en, input logic [7:0] exp);
    @(negedge clk);
    bif.reg_addr = a; bif.reg_read_en = en;
    #1;
    $display("read %h en=%0d -> %h", a, en, bif.reg_rdata);
    check(name, {56'h0, bif.reg_rdata}, {56'h0, exp});
    bif.reg_read_en = 1'b0;
  endtask

  // Counts active cycles from the first post-trigger cycle until idle
  task automatic wait_idle(input string name, output int n);
    n = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!bif.dma_active) break;
      n++;
    end
    if (bif.dma_active) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic check_oam(input string name, input logic [7:0] hi, input int lo, input int up);
    int errs = 0;
    for (int i = lo; i <= up; i++)
      if (mem[{8'hFE, 8'(i)}] !== mem[{hi, 8'(i)}]) errs++;
    check(name, 64'(errs), 64'd0);
  endtask

  initial begin
    int n, rd, wr, ov, act, first_rd, last_wr;
    logic [15:0] first_rd_addr, last_wr_addr;
    logic [7:0]  first_wd;
    reset = 1'b1;
    bif.reg_addr = 16'h0; bif.reg_wdata = 8'h0;
    bif.reg_read_en = 1'b0; bif.reg_write_en = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[{8'hC1, 8'(i)}] = 8'(i) ^ 8'h5A;
      mem[{8'hC3, 8'(i)}] = 8'(i) ^ 8'h33;
      mem[{8'hDE, 8'(i)}] = 8'(i) ^ 8'hA5;
      mem[{8'hD0, 8'(i)}] = 8'(i) + 8'h07;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // register port after reset
    reg_read("rd_reset_page", 16'hFF46, 1'b1, 8'hFF);
    reg_read("rd_other_addr", 16'hFF45, 1'b1, 8'h00);
    reg_read("rd_no_strobe", 16'hFF46, 1'b0, 8'h00);

    // basic copy with hand-pinned timing
    trigger(16'hFF46, 8'hC1);
    rd = 0; wr = 0; ov = 0; act = 0; first_rd = -1; last_wr = -1;
    first_rd_addr = 0; last_wr_addr = 0; first_wd = 0;
    for (int d = 0; d < 650; d++) begin
      @(negedge clk);
      if (bif.dma_active) act++;
      if (bif.dma_read_en && bif.dma_write_en) ov++;
      if (bif.dma_read_en) begin
        if (rd == 0) begin first_rd = d; first_rd_addr = bif.dma_addr; end
        rd++;
      end
      if (bif.dma_write_en) begin
        if (wr == 0) first_wd = bif.dma_wdata;
        wr++; last_wr = d; last_wr_addr = bif.dma_addr;
      end
    end
    check("first_read_offset", 64'(first_rd), 64'd4);
    check("first_read_addr", 64'(first_rd_addr), 64'hC100);
    check("first_write_data", 64'(first_wd), 64'h5A);
    check("last_write_offset", 64'(last_wr), 64'd641);
    check("last_write_addr", 64'(last_wr_addr), 64'hFE9F);
    check("active_cycles", 64'(act), 64'd644);
    check("read_count", 64'(rd), 64'd160);
    check("write_count", 64'(wr), 64'd160);
    check("strobe_overlap", 64'(ov), 64'd0);
    check("oam_last_byte", 64'(mem[16'hFE9F]), 64'hC5);
    check_oam("oam_basic", 8'hC1, 0, 159);

    // echo mirror pages
    trigger(16'hFF46, 8'hE3);
    wait_idle("echo_e3", n);
    check("echo_e3_len", 64'(n), 64'd644);
    check_oam("oam_echo_e3", 8'hC3, 0, 159);
    trigger(16'hFF46, 8'hFE);
    wait_idle("echo_fe", n);
    check_oam("oam_echo_fe", 8'hDE, 0, 159);
    check("oam_echo_fe_byte0", 64'(mem[16'hFE00]), 64'hA5);

    // retrigger after 50 bytes written
    trigger(16'hFF46, 8'hC1);
    wr = 0;
    for (int c = 0; c < 400 && wr < 50; c++) begin
      @(negedge clk);
      if (bif.dma_write_en) wr++;
    end
    check("retrig_50_writes", 64'(wr), 64'd50);
    trigger(16'hFF46, 8'hD0);
    wait_idle("retrig", n);
    check("retrig_len", 64'(n), 64'd644);
    check_oam("oam_retrig", 8'hD0, 0, 159);
    check("oam_retrig_byte0", 64'(mem[16'hFE00]), 64'h07);

    // reset during byte 20's PAD
    for (int i = 0; i < 160; i++) mem[{8'hFE, 8'(i)}] = 8'hEE;
    trigger(16'hFF46, 8'hC3);
    repeat (85) @(posedge clk);
    pulse_reset();
    @(negedge clk);
    check("rst_idle", {61'h0, bif.dma_active, bif.dma_read_en, bif.dma_write_en}, 64'd0);
    repeat (5) @(negedge clk);
    check_oam("oam_rst_written", 8'hC3, 0, 20);
    n = 0;
    for (int i = 21; i < 160; i++) if (mem[{8'hFE, 8'(i)}] !== 8'hEE) n++;
    check("oam_rst_untouched", 64'(n), 64'd0);
    reg_read("rd_after_rst", 16'hFF46, 1'b1, 8'hFF);

    // page write read-back, then stop with reset
    trigger(16'hFF46, 8'h80);
    reg_read("rd_page_80", 16'hFF46, 1'b1, 8'h80);
    pulse_reset();

    // write to a neighbouring address is ignored
    trigger(16'hFF47, 8'hC1);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bif.dma_active) n++;
    end
    check("ff47_no_active", 64'(n), 64'd0);
    reg_read("rd_after_ff47", 16'hFF46, 1'b1, 8'hFF);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
